// File: rtl/seg_pkg.sv
// Shared types and widths for the segment display write arbiter.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAPW = 2'd2
    } state_t;

    localparam int DISP_W = 5;
    localparam int NIB_W  = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request at or after the pointer.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    int w_dist;
    int w_best;

    // Smallest forward distance from the pointer wins; distance wraps at N.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_dist  = 0;
        w_best  = N;
        for (int c = 0; c < N; c++) begin
            w_dist = c - int'(i_ptr);
            if (w_dist < 0) w_dist = w_dist + N;
            if (i_req[c] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = IW'(c);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_wr_arbiter.sv
// Burst-atomic round-robin arbiter for the 6-digit display write port.
module seg_wr_arbiter
    import seg_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int GAP       = 3,
    parameter int MAX_BURST = 6,
    parameter int TIMEOUT   = 255,
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NIB_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic [DISP_W-1:0]       disp_wr,
    output logic                    busy,
    output logic [IW-1:0]           gnt_id,
    output logic                    abort
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_t            r_state, w_state;
    logic [IW-1:0]     r_ptr, w_ptr;
    logic [IW-1:0]     r_gnt, w_gnt;
    logic [3:0]        r_beat, w_beat;
    logic [GW-1:0]     r_gap, w_gap;
    logic [7:0]        r_to, w_to;
    logic              r_rel, w_rel;
    logic [DISP_W-1:0] r_disp, w_disp;
    logic              r_abort, w_abort;

    logic [IW-1:0]     w_idx;
    logic              w_found;
    logic              w_hs;
    logic              w_release;
    logic [IW-1:0]     w_nptr;
    logic [NIB_W-1:0]  w_nib;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign w_hs   = (r_state == XFER) && req_valid[r_gnt];
    assign w_nib  = req_data[r_gnt*NIB_W +: NIB_W];
    assign w_nptr = (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;

    always_comb begin
        req_ready = '0;
        if (r_state == XFER) req_ready[r_gnt] = 1'b1;
    end

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_gnt     = r_gnt;
        w_beat    = r_beat;
        w_gap     = r_gap;
        w_to      = r_to;
        w_rel     = r_rel;
        w_disp    = '0;
        w_abort   = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt   = w_idx;
                    w_beat  = '0;
                    w_to    = '0;
                    w_state = XFER;
                end
            end
            XFER: begin
                if (w_hs) begin
                    w_disp = {1'b1, w_nib};
                    w_beat = r_beat + 4'd1;
                    w_to   = '0;
                    if (req_last[r_gnt] ||
                        (r_beat == 4'(MAX_BURST - 1))) begin
                        w_release = 1'b1;
                    end else if (GAP > 0) begin
                        w_state = GAPW;
                        w_gap   = GW'(GAP);
                        w_rel   = 1'b0;
                    end
                end else if (r_to == 8'(TIMEOUT - 1)) begin
                    w_release = 1'b1;
                    w_abort   = 1'b1;
                end else begin
                    w_to = r_to + 8'd1;
                end
            end
            GAPW: begin
                w_gap = r_gap - GW'(1);
                if (r_gap == GW'(1)) w_state = r_rel ? IDLE : XFER;
            end
            default: w_state = IDLE;
        endcase
        // One release path so last and burst limit never double-advance.
        if (w_release) begin
            w_ptr  = w_nptr;
            w_beat = '0;
            if (GAP > 0) begin
                w_state = GAPW;
                w_gap   = GW'(GAP);
                w_rel   = 1'b1;
            end else begin
                w_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_beat  <= '0;
            r_gap   <= '0;
            r_to    <= '0;
            r_rel   <= 1'b0;
            r_disp  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_gnt   <= w_gnt;
            r_beat  <= w_beat;
            r_gap   <= w_gap;
            r_to    <= w_to;
            r_rel   <= w_rel;
            r_disp  <= w_disp;
            r_abort <= w_abort;
        end
    end

    assign disp_wr = r_disp;
    assign abort   = r_abort;
    assign busy    = (r_state != IDLE);
    assign gnt_id  = r_gnt;

endmodule

// File: tb/tb_seg_wr_arbiter.sv
// Self-checking bench for seg_wr_arbiter against a burst-level schedule model.
module tb_seg_wr_arbiter;

    localparam int NREQ = 2;
    localparam int GAP  = 3;
    localparam int MB   = 6;
    localparam int TO   = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] req_valid = '0;
    logic [7:0] req_data = '0;
    logic [1:0] req_last = '0;
    logic [1:0] req_ready;
    logic [4:0] disp_wr;
    logic       busy;
    logic [0:0] gnt_id;
    logic       abort;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int base = 0;
    int m_ptr = 0;
    int m_end = 0;

    logic [4:0] q0[$], q1[$], m0[$], m1[$];
    int obs_t[$], obs_d[$], obs_g[$], obs_a[$];
    int exp_t[$], exp_d[$], exp_g[$], exp_a[$];

    always #5 clk = ~clk;

    seg_wr_arbiter #(
        .NREQ(NREQ), .GAP(GAP), .MAX_BURST(MB), .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .disp_wr   (disp_wr),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .abort     (abort)
    );

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        logic [4:0] b0, b1;
        b0 = (q0.size() > 0) ? q0[0] : 5'd0;
        b1 = (q1.size() > 0) ? q1[0] : 5'd0;
        req_valid = {q1.size() > 0, q0.size() > 0};
        req_data  = {b1[3:0], b0[3:0]};
        req_last  = {b1[4], b0[4]};
    endtask

    task automatic load(int i, int len, bit last_end);
        logic [4:0] b;
        for (int k = 0; k < len; k++) begin
            b = {last_end && (k == len - 1), 4'($urandom_range(0, 15))};
            if (i == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic step();
        logic [1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        cyc++;
        #1;
        if (disp_wr[4]) begin
            obs_t.push_back(cyc - base);
            obs_d.push_back(int'(disp_wr[3:0]));
            obs_g.push_back(int'(gnt_id));
        end
        if (abort) obs_a.push_back(cyc - base);
        n_chk++;
        if (req_ready !== 2'b00 && req_ready !== (2'b01 << gnt_id)) begin
            n_fail++;
            $display("FAIL ready_grant got %b gnt %0d", req_ready, gnt_id);
        end
        if (hs[0] && q0.size() > 0) void'(q0.pop_front());
        if (hs[1] && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    function automatic int msize(int i);
        return (i == 0) ? m0.size() : m1.size();
    endfunction

    function automatic logic [4:0] mpop(int i);
        if (i == 0) return m0.pop_front();
        return m1.pop_front();
    endfunction

    // Schedule every burst by arithmetic: grant at t, beats GAP+1 apart,
    // release at the last/limit beat or TO cycles into a starved slot.
    task automatic model();
        int t, h, g, n;
        bit rel;
        logic [4:0] b;
        t = 0;
        while (m0.size() + m1.size() > 0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && msize((m_ptr + k) % NREQ) > 0) g = (m_ptr + k) % NREQ;
            h = t + 1;
            n = 0;
            rel = 0;
            while (!rel) begin
                if (msize(g) == 0) begin
                    exp_a.push_back(h + TO - 1);
                    t = h + TO - 1 + GAP + 1;
                    rel = 1;
                end else begin
                    b = mpop(g);
                    n++;
                    exp_t.push_back(h);
                    exp_d.push_back(int'(b[3:0]));
                    exp_g.push_back(g);
                    if (b[4] || n == MB) begin
                        t = h + GAP + 1;
                        rel = 1;
                    end else begin
                        h = h + GAP + 1;
                    end
                end
            end
            m_ptr = (g + 1) % NREQ;
        end
        m_end = t;
    endtask

    task automatic run(string name);
        obs_t.delete(); obs_d.delete(); obs_g.delete(); obs_a.delete();
        exp_t.delete(); exp_d.delete(); exp_g.delete(); exp_a.delete();
        m0 = q0;
        m1 = q1;
        model();
        base = cyc + 1;
        drive();
        for (int i = 0; i < m_end + GAP + 4; i++) step();
        n_chk++;
        if (obs_t.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL %s strobe_count got %0d exp %0d",
                     name, obs_t.size(), exp_t.size());
        end
        for (int i = 0; i < exp_t.size() && i < obs_t.size(); i++) begin
            n_chk++;
            if (obs_t[i] !== exp_t[i] || obs_d[i] !== exp_d[i] ||
                obs_g[i] !== exp_g[i]) begin
                n_fail++;
                $display("FAIL %s strobe%0d got t=%0d d=%h g=%0d exp t=%0d d=%h g=%0d",
                         name, i, obs_t[i], obs_d[i], obs_g[i],
                         exp_t[i], exp_d[i], exp_g[i]);
            end
        end
        n_chk++;
        if (obs_a.size() != exp_a.size()) begin
            n_fail++;
            $display("FAIL %s abort_count got %0d exp %0d",
                     name, obs_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            n_chk++;
            if (obs_a[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL %s abort%0d got t=%0d exp t=%0d",
                         name, i, obs_a[i], exp_a[i]);
            end
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_busy got %b exp 0", name, busy);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 2'b11;
        req_data = 8'($urandom);
        req_last = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (disp_wr !== 5'h00 || req_ready !== 2'b00 ||
                busy !== 1'b0 || abort !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs got disp=%h rdy=%b busy=%b abort=%b exp 0",
                         disp_wr, req_ready, busy, abort);
            end
        end
        q0.delete();
        q1.delete();
        drive();
        rstn = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_single();
        q0.push_back(5'h0A);
        q0.push_back(5'h0B);
        q0.push_back(5'h1C);
        run("single_burst");
        load(0, 1, 1);
        load(1, 1, 1);
        run("single_ptr_after");
    endtask

    task automatic test_contention();
        do_reset();
        load(0, 2, 1);
        load(1, 2, 1);
        run("contention");
        load(0, 1, 1);
        run("contention_prep");
        load(0, 1, 1);
        load(1, 1, 1);
        run("contention_rr");
    endtask

    task automatic test_max_burst();
        load(1, 8, 0);
        load(0, 2, 1);
        run("max_burst");
    endtask

    task automatic test_timeout();
        load(0, 1, 0);
        load(1, 1, 1);
        run("timeout");
    endtask

    task automatic test_mid_reset();
        int k;
        logic [4:0] b0, b1;
        obs_t.delete(); obs_d.delete(); obs_g.delete(); obs_a.delete();
        load(0, 4, 1);
        b0 = q0[0];
        b1 = q0[1];
        base = cyc + 1;
        drive();
        k = 0;
        while (obs_t.size() < 2 && k < 60) begin
            step();
            k++;
        end
        n_chk++;
        if (obs_t.size() != 2) begin
            n_fail++;
            $display("FAIL mid_reset_prefix got %0d strobes exp 2", obs_t.size());
        end else begin
            n_chk++;
            if (obs_d[0] !== int'(b0[3:0]) || obs_d[1] !== int'(b1[3:0])) begin
                n_fail++;
                $display("FAIL mid_reset_data got %h %h exp %h %h",
                         obs_d[0], obs_d[1], b0[3:0], b1[3:0]);
            end
        end
        rstn = 1'b0;
        q0.delete();
        drive();
        repeat (3) step();
        rstn = 1'b1;
        m_ptr = 0;
        repeat (8) step();
        n_chk++;
        if (obs_t.size() != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet got %0d strobes busy=%b exp 2 busy=0",
                     obs_t.size(), busy);
        end
        load(0, 1, 1);
        load(1, 1, 1);
        run("mid_reset_rearb");
    endtask

    task automatic test_random();
        bit any;
        for (int r = 0; r < 8; r++) begin
            any = 0;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    load(i, $urandom_range(1, 8), 1);
                    any = 1;
                end
            end
            if (!any) load(0, $urandom_range(1, 8), 1);
            run("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_max_burst();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
